// File: rtl/dmem_ws.sv
// Data memory for the pipelined core: byte/half/word access with sign or zero
// extension, misalignment detection and a configurable wait-state stall.
module dmem_ws #(
    parameter int DEPTH       = 64,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [2:0]  funct3,
    input  logic [31:0] a,
    input  logic [31:0] wd,
    output logic [31:0] rd,
    output logic        stall,
    output logic        misaligned
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] idx;
    logic          illegal;
    logic          mis_dec;
    logic          wr_en;
    logic [AW-1:0] wr_idx;
    logic [3:0]    wr_be;
    logic [31:0]   wr_data;
    logic          unused_addr;

    assign idx         = a[AW+1:2];
    assign unused_addr = ^a[31:AW+2];

    function automatic logic [31:0] fmt_load(input logic [31:0] w,
                                             input logic [1:0]  off,
                                             input logic [2:0]  f3);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[8*off +: 8];
        h = off[1] ? w[31:16] : w[15:0];
        case (f3)
            3'b000:  fmt_load = {{24{b[7]}}, b};
            3'b001:  fmt_load = {{16{h[15]}}, h};
            3'b010:  fmt_load = w;
            3'b100:  fmt_load = {24'b0, b};
            3'b101:  fmt_load = {16'b0, h};
            default: fmt_load = '0;
        endcase
    endfunction

    function automatic logic [3:0] lane_be(input logic [1:0] size,
                                           input logic [1:0] off);
        case (size)
            2'b00:   lane_be = 4'b0001 << off;
            2'b01:   lane_be = off[1] ? 4'b1100 : 4'b0011;
            default: lane_be = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] lane_data(input logic [1:0]  size,
                                              input logic [31:0] d);
        case (size)
            2'b00:   lane_data = {4{d[7:0]}};
            2'b01:   lane_data = {2{d[15:0]}};
            default: lane_data = d;
        endcase
    endfunction

    // Loads accept the unsigned variants; stores accept only sb/sh/sw.
    always_comb begin
        illegal = 1'b1;
        case (funct3)
            3'b000, 3'b001, 3'b010: illegal = 1'b0;
            3'b100, 3'b101:         illegal = we;
            default:                illegal = 1'b1;
        endcase
    end

    assign mis_dec = illegal
                   | ((funct3[1:0] == 2'b01) & a[0])
                   | ((funct3[1:0] == 2'b10) & (a[1:0] != 2'b00));
    assign misaligned = req & mis_dec;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < 4; i++) begin
                if (wr_be[i]) begin
                    mem[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
                end
            end
        end
    end

    generate
        if (WAIT_CYCLES == 0) begin : g_nowait
            assign wr_en   = req & we & ~mis_dec & ~reset;
            assign wr_idx  = idx;
            assign wr_be   = lane_be(funct3[1:0], a[1:0]);
            assign wr_data = lane_data(funct3[1:0], wd);
            assign rd      = (req & ~we & ~mis_dec & ~reset)
                           ? fmt_load(mem[idx], a[1:0], funct3) : '0;
            assign stall   = 1'b0;
        end else begin : g_wait
            localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

            state_t        state;
            logic [3:0]    cnt;
            logic [AW-1:0] idx_q;
            logic [1:0]    off_q;
            logic [31:0]   wd_q;
            logic          we_q;
            logic [2:0]    f3_q;
            logic [31:0]   rdata_q;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    state   <= S_IDLE;
                    cnt     <= '0;
                    idx_q   <= '0;
                    off_q   <= '0;
                    wd_q    <= '0;
                    we_q    <= 1'b0;
                    f3_q    <= '0;
                    rdata_q <= '0;
                end else begin
                    case (state)
                        S_IDLE: begin
                            if (req && !mis_dec) begin
                                idx_q <= idx;
                                off_q <= a[1:0];
                                wd_q  <= wd;
                                we_q  <= we;
                                f3_q  <= funct3;
                                cnt   <= CNT_INIT;
                                if (WAIT_CYCLES > 1) begin
                                    state <= S_WAIT;
                                end else begin
                                    state   <= S_DONE;
                                    rdata_q <= mem[idx];
                                end
                            end
                        end
                        S_WAIT: begin
                            if (!req) begin
                                state <= S_IDLE;
                                cnt   <= '0;
                            end else if (cnt <= 4'd1) begin
                                state   <= S_DONE;
                                cnt     <= '0;
                                rdata_q <= mem[idx_q];
                            end else begin
                                cnt <= cnt - 4'd1;
                            end
                        end
                        default: state <= S_IDLE;
                    endcase
                end
            end

            // A store lands on the edge leaving DONE, so a following load's
            // array read (on a later edge) always sees it.
            assign wr_en   = (state == S_DONE) & req & we_q & ~reset;
            assign wr_idx  = idx_q;
            assign wr_be   = lane_be(f3_q[1:0], off_q);
            assign wr_data = lane_data(f3_q[1:0], wd_q);

            assign rd    = ((state == S_DONE) & req & ~we_q & ~reset)
                         ? fmt_load(rdata_q, off_q, f3_q) : '0;
            assign stall = ~reset & req
                         & (((state == S_IDLE) & ~mis_dec) | (state == S_WAIT));
        end
    endgenerate

endmodule

// File: tb/tb_dmem_ws.sv
// Directed bench for dmem_ws across several DEPTH/WAIT_CYCLES configurations;
// expected load data is queued at issue time and compared at completion.
module tb_dmem_ws;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_v   [5];
    logic        we_v    [5];
    logic [2:0]  f3_v    [5];
    logic [31:0] a_v     [5];
    logic [31:0] wd_v    [5];
    logic [31:0] rd_v    [5];
    logic        stall_v [5];
    logic        mis_v   [5];

    int checks   = 0;
    int failures = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    dmem_ws #(.DEPTH(64), .WAIT_CYCLES(2)) u0 (
        .clk(clk), .reset(reset), .req(req_v[0]), .we(we_v[0]), .funct3(f3_v[0]),
        .a(a_v[0]), .wd(wd_v[0]), .rd(rd_v[0]), .stall(stall_v[0]), .misaligned(mis_v[0]));
    dmem_ws #(.DEPTH(64), .WAIT_CYCLES(0)) u1 (
        .clk(clk), .reset(reset), .req(req_v[1]), .we(we_v[1]), .funct3(f3_v[1]),
        .a(a_v[1]), .wd(wd_v[1]), .rd(rd_v[1]), .stall(stall_v[1]), .misaligned(mis_v[1]));
    dmem_ws #(.DEPTH(64), .WAIT_CYCLES(1)) u2 (
        .clk(clk), .reset(reset), .req(req_v[2]), .we(we_v[2]), .funct3(f3_v[2]),
        .a(a_v[2]), .wd(wd_v[2]), .rd(rd_v[2]), .stall(stall_v[2]), .misaligned(mis_v[2]));
    dmem_ws #(.DEPTH(64), .WAIT_CYCLES(15)) u3 (
        .clk(clk), .reset(reset), .req(req_v[3]), .we(we_v[3]), .funct3(f3_v[3]),
        .a(a_v[3]), .wd(wd_v[3]), .rd(rd_v[3]), .stall(stall_v[3]), .misaligned(mis_v[3]));
    dmem_ws #(.DEPTH(16), .WAIT_CYCLES(2)) u4 (
        .clk(clk), .reset(reset), .req(req_v[4]), .we(we_v[4]), .funct3(f3_v[4]),
        .a(a_v[4]), .wd(wd_v[4]), .rd(rd_v[4]), .stall(stall_v[4]), .misaligned(mis_v[4]));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one aligned access on instance k expecting n stall cycles, then
    // check completion data and that the block is quiet afterwards.
    task automatic access(input int k, input int n, input logic w, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] data,
                          input logic [31:0] exp_rd);
        logic [31:0] e;
        req_v[k] = 1'b1; we_v[k] = w; f3_v[k] = f3; a_v[k] = addr; wd_v[k] = data;
        exp_q.push_back(exp_rd);
        for (int c = 0; c <= n; c++) begin
            @(negedge clk);
            chk($sformatf("k%0d a%h c%0d stall", k, addr, c), {31'b0, stall_v[k]},
                (c < n) ? 32'd1 : 32'd0);
            if (c < n) begin
                chk($sformatf("k%0d a%h c%0d rd_idle", k, addr, c), rd_v[k], 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk($sformatf("k%0d a%h rd", k, addr), rd_v[k], e);
                chk($sformatf("k%0d a%h mis", k, addr), {31'b0, mis_v[k]}, 32'd0);
            end
            @(posedge clk); #1;
        end
        req_v[k] = 1'b0;
        @(negedge clk);
        chk($sformatf("k%0d a%h after_stall", k, addr), {31'b0, stall_v[k]}, 32'd0);
        chk($sformatf("k%0d a%h after_rd", k, addr), rd_v[k], 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic bad_access(input logic w, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] data);
        logic [31:0] e;
        req_v[0] = 1'b1; we_v[0] = w; f3_v[0] = f3; a_v[0] = addr; wd_v[0] = data;
        exp_q.push_back(32'd0);
        @(negedge clk);
        e = exp_q.pop_front();
        chk($sformatf("mis a%h f%0d flag", addr, f3), {31'b0, mis_v[0]}, 32'd1);
        chk($sformatf("mis a%h f%0d stall", addr, f3), {31'b0, stall_v[0]}, 32'd0);
        chk($sformatf("mis a%h f%0d rd", addr, f3), rd_v[0], e);
        @(posedge clk); #1;
        req_v[0] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < 5; k++) begin
            req_v[k] = 1'b0; we_v[k] = 1'b0; f3_v[k] = 3'b010; a_v[k] = '0; wd_v[k] = '0;
        end
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset stall", {31'b0, stall_v[0]}, 32'd0);
        chk("reset rd", rd_v[0], 32'd0);
        chk("reset mis", {31'b0, mis_v[0]}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        // Word store/load, WAIT_CYCLES=2
        access(0, 2, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0);
        access(0, 2, 1'b0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF);

        // Byte/half formatting
        access(0, 2, 1'b1, 3'b010, 32'h20, 32'h80F07F81, 32'h0);
        access(0, 2, 1'b0, 3'b000, 32'h20, 32'h0, 32'hFFFFFF81);
        access(0, 2, 1'b0, 3'b100, 32'h20, 32'h0, 32'h00000081);
        access(0, 2, 1'b0, 3'b001, 32'h22, 32'h0, 32'hFFFF80F0);
        access(0, 2, 1'b0, 3'b101, 32'h22, 32'h0, 32'h000080F0);
        access(0, 2, 1'b1, 3'b000, 32'h21, 32'hFFFFFF55, 32'h0);
        access(0, 2, 1'b0, 3'b010, 32'h20, 32'h0, 32'h80F05581);
        access(0, 2, 1'b1, 3'b001, 32'h12, 32'h00001234, 32'h0);
        access(0, 2, 1'b0, 3'b010, 32'h10, 32'h0, 32'h1234BEEF);

        // Misalignment and illegal funct3; memory must be untouched
        bad_access(1'b0, 3'b010, 32'h22, 32'h0);
        bad_access(1'b1, 3'b001, 32'h13, 32'h0000AAAA);
        bad_access(1'b0, 3'b011, 32'h20, 32'h0);
        bad_access(1'b1, 3'b100, 32'h20, 32'h000000AA);
        access(0, 2, 1'b0, 3'b010, 32'h10, 32'h0, 32'h1234BEEF);
        access(0, 2, 1'b0, 3'b010, 32'h20, 32'h0, 32'h80F05581);

        // Flush: req dropped in the second stall cycle
        access(0, 2, 1'b1, 3'b010, 32'h30, 32'hCAFEF00D, 32'h0);
        req_v[0] = 1'b1; we_v[0] = 1'b1; f3_v[0] = 3'b010; a_v[0] = 32'h30; wd_v[0] = 32'h12345678;
        @(negedge clk);
        chk("flush stall0", {31'b0, stall_v[0]}, 32'd1);
        @(posedge clk); #1;
        req_v[0] = 1'b0;
        @(negedge clk);
        chk("flush stall1", {31'b0, stall_v[0]}, 32'd0);
        chk("flush rd1", rd_v[0], 32'd0);
        @(posedge clk); #1;
        access(0, 2, 1'b0, 3'b010, 32'h30, 32'h0, 32'hCAFEF00D);

        // Reset during the WAIT of a store
        req_v[0] = 1'b1; we_v[0] = 1'b1; f3_v[0] = 3'b010; a_v[0] = 32'h30; wd_v[0] = 32'hAAAA5555;
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        chk("rst_mid stall", {31'b0, stall_v[0]}, 32'd0);
        chk("rst_mid rd", rd_v[0], 32'd0);
        @(negedge clk);
        req_v[0] = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        access(0, 2, 1'b0, 3'b010, 32'h30, 32'h0, 32'hCAFEF00D);

        // WAIT_CYCLES=0: same-cycle loads, no stall
        access(1, 0, 1'b1, 3'b010, 32'h8, 32'h11223344, 32'h0);
        access(1, 0, 1'b0, 3'b010, 32'h8, 32'h0, 32'h11223344);
        access(1, 0, 1'b0, 3'b100, 32'h9, 32'h0, 32'h00000033);
        access(1, 0, 1'b0, 3'b001, 32'hA, 32'h0, 32'h00001122);

        // WAIT_CYCLES=1 and 15
        access(2, 1, 1'b1, 3'b010, 32'h4, 32'h0BADF00D, 32'h0);
        access(2, 1, 1'b0, 3'b010, 32'h4, 32'h0, 32'h0BADF00D);
        access(3, 15, 1'b1, 3'b010, 32'hC, 32'h76543210, 32'h0);
        access(3, 15, 1'b0, 3'b000, 32'hF, 32'h0, 32'h00000076);

        // DEPTH=16: 0x40 aliases to 0x00
        access(4, 2, 1'b1, 3'b010, 32'h40, 32'hA5A50001, 32'h0);
        access(4, 2, 1'b0, 3'b010, 32'h00, 32'h0, 32'hA5A50001);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
